muldiv_issue: RTL

Execute-stage initiator for the M-extension multiply/divide unit. It accepts one decoded RV64M instruction from the EX stage and latches its operands. It drives the request side of the MULDIV handshake: `mul_en`, `req_valid`, operands and sign flags. It then waits for `valid`, selects and word-adjusts the correct half of the result, and holds the pipeline stalled until the result is written back.

---
 rtl/muldiv_issue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_issue.sv
// M-extension issue stage: latches one RV64M instruction, handshakes with MULDIV, writes back.
// Optional macro MULDIV_FASTPATH_EN resolves divide-by-zero and signed overflow without MULDIV.
module muldiv_issue #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            mul_en_o,
   output logic            req_valid_o,
   output logic [XLEN-1:0] op_1_o,
   output logic [XLEN-1:0] op_2_o,
   output logic            sign_op_1_o,
   output logic            sign_op_2_o,
   input  logic            ready_i,
   input  logic            valid_i,
   input  logic [XLEN-1:0] data_1_i,
   input  logic [XLEN-1:0] data_2_i,
   output logic            stall_o,
   output logic [XLEN-1:0] result_o,
   output logic            result_valid_o
);

   localparam int unsigned RegBus = XLEN;

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

   state_e            state_q, state_d;
   logic [2:0]        funct3_q;
   logic              word_q;
   logic [RegBus-1:0] op_1_q, op_2_q, result_q;
   logic              mul_en_q, sign_1_q, sign_2_q;

   logic              is_mul, sgn_1, sgn_2;
   logic [RegBus-1:0] prep_1, prep_2;
   logic [RegBus-1:0] res_raw, res_sel;
   logic              fast;
   logic [RegBus-1:0] fast_res;

   function automatic logic [RegBus-1:0] word_adj(input logic [RegBus-1:0] r);
      return {{(RegBus-32){r[31]}}, r[31:0]};
   endfunction

   // High half / remainder for everything except MUL, DIV, DIVU.
   function automatic logic sel_hi(input logic [2:0] f3);
      return !(f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd5);
   endfunction

   always_comb begin
      is_mul = ~funct3_i[2];
      case (funct3_i)
         3'd0, 3'd1, 3'd4, 3'd6: {sgn_1, sgn_2} = 2'b11;
         3'd2:                   {sgn_1, sgn_2} = 2'b10;
         default:                {sgn_1, sgn_2} = 2'b00;
      endcase
      prep_1 = rs1_i;
      prep_2 = rs2_i;
      if (word_i) begin
         prep_1 = {{(RegBus-32){sgn_1 & rs1_i[31]}}, rs1_i[31:0]};
         prep_2 = {{(RegBus-32){sgn_2 & rs2_i[31]}}, rs2_i[31:0]};
      end
   end

`ifdef MULDIV_FASTPATH_EN
   localparam logic [RegBus-1:0] MinNeg  = {1'b1, {(RegBus-1){1'b0}}};
   localparam logic [RegBus-1:0] MinNegW = {{(RegBus-31){1'b1}}, {31{1'b0}}};

   logic              div_zero, div_ovf;
   logic [RegBus-1:0] fast_quo, fast_rem, fast_raw;

   always_comb begin
      div_zero = ~is_mul & (prep_2 == '0);
      div_ovf  = ~is_mul & sgn_1 & (prep_1 == (word_i ? MinNegW : MinNeg)) & (prep_2 == '1);
      fast     = div_zero | div_ovf;
      fast_quo = div_zero ? '1 : prep_1;
      fast_rem = div_zero ? prep_1 : '0;
      fast_raw = sel_hi(funct3_i) ? fast_rem : fast_quo;
      fast_res = word_i ? word_adj(fast_raw) : fast_raw;
   end
`else
   assign fast     = 1'b0;
   assign fast_res = '0;
`endif

   always_comb begin
      res_raw = sel_hi(funct3_q) ? data_2_i : data_1_i;
      res_sel = word_q ? word_adj(res_raw) : res_raw;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = fast ? StDone : StReq;
         StReq: begin
            if (flush_i)      state_d = StIdle;
            else if (ready_i) state_d = StWait;
         end
         StWait: begin
            if (flush_i && valid_i) state_d = StIdle;
            else if (flush_i)       state_d = StDrain;
            else if (valid_i)       state_d = StDone;
         end
         StDrain: if (valid_i) state_d = StIdle;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         funct3_q <= '0;
         word_q   <= 1'b0;
         op_1_q   <= '0;
         op_2_q   <= '0;
         mul_en_q <= 1'b0;
         sign_1_q <= 1'b0;
         sign_2_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start_i) begin
            funct3_q <= funct3_i;
            word_q   <= word_i;
            op_1_q   <= prep_1;
            op_2_q   <= prep_2;
            mul_en_q <= is_mul;
            sign_1_q <= sgn_1;
            sign_2_q <= sgn_2;
            if (fast) result_q <= fast_res;
         end
         if (state_q == StWait && valid_i && !flush_i) result_q <= res_sel;
      end
   end

   // A flush in REQ withdraws the request in the same cycle so MULDIV never accepts it.
   assign req_valid_o    = (state_q == StReq) & ~flush_i;
   assign result_valid_o = (state_q == StDone);
   assign stall_o        = ((state_q == StIdle) & start_i) | (state_q == StReq) |
                           (state_q == StWait) | (state_q == StDrain);
   assign mul_en_o       = mul_en_q;
   assign sign_op_1_o    = sign_1_q;
   assign sign_op_2_o    = sign_2_q;
   assign op_1_o         = op_1_q;
   assign op_2_o         = op_2_q;
   assign result_o       = result_q;

endmodule
